// File: rtl/sound_pkg.sv
// Sound scheduler shared definitions: sound codes, FSM encoding and per-note tables.
package sound_pkg;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_BEEP  = 3'd1;
  localparam logic [2:0] CODE_CHIRP = 3'd2;
  localparam logic [2:0] CODE_OVER  = 3'd3;

  // Silence appended after every sound
  localparam int unsigned GAP_MS = 20;

  typedef enum logic [1:0] {StIdle, StLoad, StTone, StGap} state_e;

  // Note pitch in Hz for a given sound and note index
  function automatic int unsigned note_hz(logic [2:0] code, logic [1:0] idx);
    int unsigned hz;
    case ({code, idx})
      {CODE_BEEP,  2'd0}: hz = 880;
      {CODE_CHIRP, 2'd0}: hz = 660;
      {CODE_CHIRP, 2'd1}: hz = 990;
      {CODE_OVER,  2'd0}: hz = 523;
      {CODE_OVER,  2'd1}: hz = 392;
      {CODE_OVER,  2'd2}: hz = 262;
      default:            hz = 880;
    endcase
    return hz;
  endfunction

  // Note length in milliseconds
  function automatic int unsigned note_ms(logic [2:0] code);
    int unsigned ms;
    case (code)
      CODE_CHIRP: ms = 60;
      CODE_OVER:  ms = 200;
      default:    ms = 80;
    endcase
    return ms;
  endfunction

  // True when idx is the final note of the sound
  function automatic logic note_last(logic [2:0] code, logic [1:0] idx);
    logic last;
    case (code)
      CODE_CHIRP: last = (idx == 2'd1);
      CODE_OVER:  last = (idx == 2'd2);
      default:    last = 1'b1;
    endcase
    return last;
  endfunction

  // Clock cycles per half period of a square wave at hz
  function automatic int unsigned half_cycles(int unsigned clk_hz, int unsigned hz);
    return clk_hz / (2 * hz);
  endfunction

endpackage

// File: rtl/sound_fifo.sv
// Small synchronous request queue with full/empty flags and a content match probe.
module sound_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] match,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             hit
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // Full is judged before a same-cycle pop frees a slot
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Flag whether any occupied slot holds the match value
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ({1'b0, AW'(i) - rd_ptr_q} < count_q && mem_q[i] == match) begin
        hit = 1'b1;
      end
    end
  end

  // Pointer, occupancy and storage update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sound_sched.sv
// Buzzer sound scheduler: queues sound requests and plays their note sequences.
// Optional build macro SOUND_PREEMPT_EN: a fresh game-over request flushes the
// queue and replaces the sound in progress.
module sound_sched #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       play_sound,
  input  logic [2:0] sound_code,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] cur_code,
  output logic [7:0] drop_cnt
);

  import sound_pkg::*;

  localparam int unsigned MS_CYC   = CLK_HZ / 1000;
  localparam int unsigned HALF_1_0 = half_cycles(CLK_HZ, note_hz(CODE_BEEP, 2'd0));
  localparam int unsigned HALF_2_0 = half_cycles(CLK_HZ, note_hz(CODE_CHIRP, 2'd0));
  localparam int unsigned HALF_2_1 = half_cycles(CLK_HZ, note_hz(CODE_CHIRP, 2'd1));
  localparam int unsigned HALF_3_0 = half_cycles(CLK_HZ, note_hz(CODE_OVER, 2'd0));
  localparam int unsigned HALF_3_1 = half_cycles(CLK_HZ, note_hz(CODE_OVER, 2'd1));
  localparam int unsigned HALF_3_2 = half_cycles(CLK_HZ, note_hz(CODE_OVER, 2'd2));

  // Half-period selection from elaboration-time constants, keeping dividers out of logic
  function automatic logic [31:0] note_half(logic [2:0] code, logic [1:0] idx);
    logic [31:0] h;
    case ({code, idx})
      {CODE_CHIRP, 2'd0}: h = HALF_2_0;
      {CODE_CHIRP, 2'd1}: h = HALF_2_1;
      {CODE_OVER,  2'd0}: h = HALF_3_0;
      {CODE_OVER,  2'd1}: h = HALF_3_1;
      {CODE_OVER,  2'd2}: h = HALF_3_2;
      default:            h = HALF_1_0;
    endcase
    return h;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cur_code_q, cur_code_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] hp_q, hp_d, pre_q, pre_d, dur_q, dur_d;
  logic        tone_q, tone_d, buzzer_q;
  logic [7:0]  drop_q;

  logic       valid_req, over_active, coalesce, preempt, push_req, drop, pop, ms_tick;
  logic [2:0] fifo_rdata;
  logic       fifo_full, fifo_empty, fifo_hit;

  assign valid_req = play_sound && (sound_code == CODE_BEEP || sound_code == CODE_CHIRP ||
                                    sound_code == CODE_OVER);
  // Game-over already sounding or waiting: repeated strobes collapse into it
  assign over_active = ((state_q != StIdle) && (cur_code_q == CODE_OVER)) || fifo_hit;
  assign coalesce    = valid_req && (sound_code == CODE_OVER) && over_active;
`ifdef SOUND_PREEMPT_EN
  assign preempt = valid_req && (sound_code == CODE_OVER) && !over_active;
`else
  assign preempt = 1'b0;
`endif
  assign push_req = valid_req && !coalesce && !preempt;
  assign drop     = push_req && fifo_full;
  assign ms_tick  = (pre_q == MS_CYC - 1);

  sound_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (preempt),
    .push  (push_req),
    .pop   (pop),
    .wdata (sound_code),
    .match (CODE_OVER),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .hit   (fifo_hit)
  );

  // Sequencer next state: note loading, tone generation, ms timing and gap
  always_comb begin
    state_d    = state_q;
    cur_code_d = cur_code_q;
    idx_d      = idx_q;
    hp_d       = hp_q;
    pre_d      = pre_q;
    dur_d      = dur_q;
    tone_d     = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur_code_d = CODE_NONE;
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_code_d = fifo_rdata;
          idx_d      = 2'd0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        hp_d    = note_half(cur_code_q, idx_q) - 32'd1;
        dur_d   = note_ms(cur_code_q) - 1;
        pre_d   = '0;
        state_d = StTone;
      end
      StTone: begin
        tone_d = tone_q;
        if (hp_q == '0) begin
          tone_d = ~tone_q;
          hp_d   = note_half(cur_code_q, idx_q) - 32'd1;
        end else begin
          hp_d = hp_q - 32'd1;
        end
        if (ms_tick) begin
          pre_d = '0;
          if (dur_q == '0) begin
            tone_d = 1'b0;
            if (note_last(cur_code_q, idx_q)) begin
              dur_d   = GAP_MS - 1;
              state_d = StGap;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = StLoad;
            end
          end else begin
            dur_d = dur_q - 32'd1;
          end
        end else begin
          pre_d = pre_q + 32'd1;
        end
      end
      StGap: begin
        if (ms_tick) begin
          pre_d = '0;
          if (dur_q == '0) begin
            cur_code_d = CODE_NONE;
            state_d    = StIdle;
          end else begin
            dur_d = dur_q - 32'd1;
          end
        end else begin
          pre_d = pre_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (preempt) begin
      state_d    = StLoad;
      cur_code_d = CODE_OVER;
      idx_d      = 2'd0;
      tone_d     = 1'b0;
      pop        = 1'b0;
    end
  end

  // State, counters, registered buzzer and saturating drop counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cur_code_q <= CODE_NONE;
      idx_q      <= '0;
      hp_q       <= '0;
      pre_q      <= '0;
      dur_q      <= '0;
      tone_q     <= 1'b0;
      buzzer_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= cur_code_d;
      idx_q      <= idx_d;
      hp_q       <= hp_d;
      pre_q      <= pre_d;
      dur_q      <= dur_d;
      tone_q     <= tone_d;
      buzzer_q   <= tone_d & ~mute;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign buzzer   = buzzer_q;
  assign busy     = (state_q != StIdle) || !fifo_empty;
  assign cur_code = cur_code_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sound_sched.sv
// Directed bench for sound_sched at CLK_HZ=20000 (1 ms = 20 cycles).
// Half periods: 880->11, 660->15, 990->10, 523->19, 392->25, 262->38 cycles.
module tb_sound_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       play_sound = 1'b0;
  logic [2:0] sound_code = 3'd0;
  logic       mute = 1'b0;
  logic       buzzer, busy;
  logic [2:0] cur_code;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

`ifdef SOUND_PREEMPT_EN
  localparam int L3 = 0;
  localparam int EXP_SEQ = 23;
  localparam int EXP_AT_101 = 3;
`else
  localparam int L3 = 1;
  localparam int EXP_SEQ = 213;
  localparam int EXP_AT_101 = 2;
`endif

  sound_sched #(
    .CLK_HZ     (20_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .play_sound (play_sound),
    .sound_code (sound_code),
    .mute       (mute),
    .buzzer     (buzzer),
    .busy       (busy),
    .cur_code   (cur_code),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_buzz(input logic lvl, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge clk);
      if (buzzer === lvl) t = cyc;
    end
  endtask

  task automatic wait_code(input logic [2:0] code, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge clk);
      if (cur_code === code) t = cyc;
    end
  endtask

  task automatic wait_idle(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge clk);
      if (busy === 1'b0) t = cyc;
    end
  endtask

  initial begin
    int p, t, t2, seq, last;

    // Asynchronous reset values
    #2 rstn = 1'b0;
    #1;
    check_val("rst_buzzer", buzzer, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_code", cur_code, 0);
    check_val("rst_drop", drop_cnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Codes 0, 5, 7 are ignored
    @(negedge clk); play_sound = 1'b1; sound_code = 3'd0;
    @(negedge clk); sound_code = 3'd5;
    @(negedge clk); sound_code = 3'd7;
    @(negedge clk); play_sound = 1'b0;
    @(negedge clk);
    check_val("bad_code_busy", busy, 0);
    check_val("bad_code_drop", drop_cnt, 0);

    // Single code 1
    @(negedge clk); play_sound = 1'b1; sound_code = 3'd1; p = cyc + 1;
    @(negedge clk); play_sound = 1'b0;
    check_val("c1_busy_push", busy, 1);
    check_val("c1_code_pre", cur_code, 0);
    wait_code(3'd1, 10, t);       check_val("c1_load_lat", t - p, 1);
    wait_buzz(1'b1, 100, t);      check_val("c1_first_rise", t - p, 13);
    wait_buzz(1'b0, 100, t2);     check_val("c1_half", t2 - t, 11);
    wait_idle(5000, t);           check_val("c1_idle_at", t - p, 2002);
    check_val("c1_code_clr", cur_code, 0);

    // Codes 2 then 1 back to back
    do_reset();
    @(negedge clk); play_sound = 1'b1; sound_code = 3'd2; p = cyc + 1;
    @(negedge clk); sound_code = 3'd1;
    @(negedge clk); play_sound = 1'b0;
    wait_buzz(1'b1, 100, t);      check_val("c2_n0_rise", t - p, 17);
    wait_buzz(1'b0, 100, t2);     check_val("c2_n0_half", t2 - t, 15);
    wait_to(p + 1203);
    wait_buzz(1'b1, 100, t);      check_val("c2_n1_rise", t - p, 1213);
    wait_buzz(1'b0, 100, t2);     check_val("c2_n1_half", t2 - t, 10);
    wait_code(3'd1, 3000, t);     check_val("c21_next_load", t - p, 2804);
    wait_buzz(1'b1, 100, t);      check_val("c21_c1_rise", t - p, 2816);
    wait_idle(5000, t);           check_val("c21_idle_at", t - p, 4805);

    // Six code-1 strobes: one pops, four queue, one drops; then mute and reset
    do_reset();
    @(negedge clk); play_sound = 1'b1; sound_code = 3'd1; p = cyc + 1;
    repeat (6) @(negedge clk);
    play_sound = 1'b0;
    check_val("six_drop", drop_cnt, 1);
    check_val("six_code", cur_code, 1);
    wait_to(p + 14);
    check_val("mute_pre", buzzer, 1);
    mute = 1'b1;
    @(negedge clk);
    check_val("mute_fast", buzzer, 0);
    wait_to(p + 30);
    mute = 1'b0;
    wait_buzz(1'b1, 100, t);      check_val("mute_timing", t - p, 35);
    #3 rstn = 1'b0;
    #1;
    check_val("arst_buzzer", buzzer, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_code", cur_code, 0);
    check_val("arst_drop", drop_cnt, 0);
    @(negedge clk); rstn = 1'b1;
    repeat (10) @(negedge clk);
    check_val("no_replay", busy, 0);

    // Code 3 held for 1000 cycles plays once
    do_reset();
    @(negedge clk); play_sound = 1'b1; sound_code = 3'd3; p = cyc + 1;
    wait_buzz(1'b1, 100, t);      check_val("c3_n0_rise", t - p, L3 + 20);
    wait_buzz(1'b0, 100, t2);     check_val("c3_n0_half", t2 - t, 19);
    wait_to(p + 999);
    play_sound = 1'b0;
    wait_to(p + L3 + 4002);
    wait_buzz(1'b1, 100, t);      check_val("c3_n1_rise", t - p, L3 + 4027);
    wait_buzz(1'b0, 100, t2);     check_val("c3_n1_half", t2 - t, 25);
    wait_to(p + L3 + 8003);
    wait_buzz(1'b1, 100, t);      check_val("c3_n2_rise", t - p, L3 + 8041);
    wait_buzz(1'b0, 100, t2);     check_val("c3_n2_half", t2 - t, 38);
    wait_idle(6000, t);           check_val("c3_idle_at", t - p, L3 + 12403);
    check_val("c3_drop", drop_cnt, 0);
    repeat (20) @(negedge clk);
    check_val("c3_once", busy, 0);

    // Code 2 playing, code 1 queued, then code 3
    do_reset();
    @(negedge clk); play_sound = 1'b1; sound_code = 3'd2; p = cyc + 1;
    @(negedge clk); sound_code = 3'd1;
    @(negedge clk); play_sound = 1'b0;
    seq = 0; last = 0; t = -1;
    for (int i = 0; i < 30000 && t < 0; i++) begin
      @(negedge clk);
      if (cyc == p + 100) begin
        play_sound = 1'b1;
        sound_code = 3'd3;
      end
      if (cyc == p + 101) begin
        play_sound = 1'b0;
        check_val("pre_code_101", cur_code, EXP_AT_101);
      end
      if (cur_code != 3'd0 && int'(cur_code) != last) begin
        seq  = seq * 10 + int'(cur_code);
        last = int'(cur_code);
      end
      if (busy === 1'b0 && cyc > p + 101) t = cyc;
    end
    check_val("pre_order", seq, EXP_SEQ);
    check_val("pre_done", int'(t >= 0), 1);
    check_val("pre_drop", drop_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_sched.md
SOUND_SCHED -- requirements
Module: sound_sched

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, request queue depth (power of two, >=2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port play_sound  input  1  request strobe, sampled every cycle.
REQ-006 SHALL have port sound_code  input  3  requested sound, valid when play_sound=1.
REQ-007 SHALL have port mute  input  1  silences buzzer; sequencing continues.
REQ-008 SHALL have port buzzer  output  1  square-wave drive to speaker.
REQ-009 SHALL have port busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-010 SHALL have port cur_code  output  3  code being played, 0 in IDLE.
REQ-011 SHALL have port drop_cnt  output  8  dropped-request count, saturates at 255.

Function
REQ-012 SHALL map sounds: code 1 = 880 Hz 80 ms; code 2 = 660 Hz 60 ms then 990 Hz 60 ms; code 3 = 523, 392, 262 Hz, 200 ms each.
REQ-013 SHALL ignore codes 0 and 4-7: no push, no drop count.
REQ-014 SHALL push a valid request into the FIFO on the clock edge where play_sound=1.
REQ-015 SHALL drop a valid request when the FIFO is full, incrementing drop_cnt (saturating).
REQ-016 SHALL silently discard, without counting, a code-3 request while code 3 is playing or queued (coalesces held game-over strobes).
REQ-017 SHALL support simultaneous push and pop in one cycle; full is evaluated before the pop.
REQ-018 SHALL implement states IDLE, LOAD, TONE, GAP.
REQ-019 IDLE: FIFO non-empty -> pop, latch cur_code, note index 0 -> LOAD.
REQ-020 LOAD: load half-period counter, duration counter, clear ms prescaler -> TONE (one cycle).
REQ-021 TONE: internal tone toggles each time the half-period counter expires; half-period = floor(CLK_HZ/(2*f)) cycles.
REQ-022 TONE: duration counted in ms via prescaler of CLK_HZ/1000 cycles; on expiry, next note exists -> index+1, LOAD; else GAP.
REQ-023 GAP: tone low, 20 ms silence -> IDLE, cur_code=0.
REQ-024 Latency: request at edge N into empty FIFO in IDLE -> LOAD at N+2, TONE at N+3, first toggle one half-period later.
REQ-025 buzzer SHALL equal internal tone AND NOT mute, registered; tone forced 0 outside TONE.

Reset
REQ-026 On rstn low, asynchronously: state IDLE, FIFO empty, buzzer 0, busy 0, cur_code 0, drop_cnt 0, all counters 0.
REQ-027 Reset mid-sound SHALL abort immediately; no request pending at reset is replayed.

Configuration
REQ-028 With SOUND_PREEMPT_EN defined, a code-3 request not coalesced by REQ-016 SHALL flush the FIFO, abort the current sound, and enter LOAD with code 3 next cycle; flushed entries are not counted as drops.
REQ-029 Without SOUND_PREEMPT_EN, code 3 SHALL be queued FIFO-order like any other code.

Structure
REQ-030 Package sound_pkg SHALL hold sound-code constants, state encoding, per-note frequency/duration tables, and GAP_MS=20.
REQ-031 The queue SHALL be a separate sub-module sound_fifo (synchronous, width 3, depth FIFO_DEPTH, full/empty flags).

Verification (CLK_HZ=1_000_000)
REQ-032 Single code 1 -> LOAD 2 cycles later; buzzer half-period 568 cycles; TONE 80000 cycles; GAP 20000; busy falls after.
REQ-033 Codes 2,1 back-to-back -> code 2 notes at half-periods 757 then 505, 60 ms each, GAP, then code 1 played.
REQ-034 Six code-1 strobes while idle with FIFO_DEPTH=4 -> first pops next cycle, four queued, one dropped, drop_cnt=1.
REQ-035 play_sound held with code 3 for 1000 cycles -> exactly one code-3 sound (956/1275/1908 half-periods), drop_cnt unchanged.
REQ-036 Code 2 playing with code 1 queued, then code 3 -> with SOUND_PREEMPT_EN: code 3 LOAD next cycle, code 1 never plays; without: order 2,1,3.
REQ-037 mute high mid-tone -> buzzer 0 next cycle, state timing unchanged; rstn low mid-TONE -> all outputs 0 asynchronously.
